ysyx_22050854_axi_lite_sram: RTL and testbench

AXI4-Lite slave that sits directly downstream of the IFU/LSU arbiter and services the single granted request stream against an on-chip word-addressed SRAM model. It accepts one transaction at a time, inserts a programmable access latency to emulate a slow memory, applies byte strobes on writes, and returns OKAY or SLVERR responses. Both the IFU and LSU paths see it only through the arbiter.

---
 rtl/ysyx_22050854_axi_lite_sram.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_22050854_axi_lite_sram.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_axi_lite_sram.sv
// AXI4-Lite slave in front of a word-addressed on-chip SRAM model.
// One transaction at a time, with a fixed extra latency per access to emulate slow memory.
module ysyx_22050854_axi_lite_sram #(
  parameter int                 DATA_W  = 64,
  parameter int                 ADDR_W  = 32,
  parameter int                 DEPTH   = 4096,
  parameter logic [ADDR_W-1:0]  BASE    = 32'h8000_0000,
  parameter int                 LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   LIMIT    = {1'b0, BASE} + (ADDR_W+1)'(DEPTH * 8);
  localparam logic [3:0]        LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [1:0]        OKAY     = 2'b00;
  localparam logic [1:0]        SLVERR   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RWAIT, S_RRESP, S_WWAIT, S_BRESP} state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0]   old_w,
                                                    input logic [DATA_W-1:0]   new_w,
                                                    input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < DATA_W/8; i++)
      if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    return res;
  endfunction

  logic [DATA_W-1:0]   r_mem [DEPTH];
  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic [1:0]          r_bresp;

  logic                w_rd_commit;
  logic                w_wr_commit;
  logic                w_cnt_load;
  logic                w_arready;
  logic                w_awready;
  logic                w_wr_req;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic [DATA_W/8-1:0] w_wr_strb;

  assign w_wr_req = awvalid & wvalid;

  // With zero latency the commit happens straight out of IDLE, so use the live bus values there.
  assign w_rd_addr = (r_state == S_IDLE) ? araddr : r_addr;
  assign w_wr_addr = (r_state == S_IDLE) ? awaddr : r_addr;
  assign w_wr_data = (r_state == S_IDLE) ? wdata  : r_wdata;
  assign w_wr_strb = (r_state == S_IDLE) ? wstrb  : r_wstrb;

  always_comb begin
    w_next      = r_state;
    w_rd_commit = 1'b0;
    w_wr_commit = 1'b0;
    w_cnt_load  = 1'b0;
    w_arready   = 1'b0;
    w_awready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_arready = 1'b1;
        w_awready = w_wr_req & ~arvalid;
        if (arvalid) begin
          if (LATENCY == 0) begin
            w_next      = S_RRESP;
            w_rd_commit = 1'b1;
          end else begin
            w_next     = S_RWAIT;
            w_cnt_load = 1'b1;
          end
        end else if (w_wr_req) begin
          if (LATENCY == 0) begin
            w_next      = S_BRESP;
            w_wr_commit = 1'b1;
          end else begin
            w_next     = S_WWAIT;
            w_cnt_load = 1'b1;
          end
        end
      end
      S_RWAIT: begin
        if (r_cnt == 4'd0) begin
          w_next      = S_RRESP;
          w_rd_commit = 1'b1;
        end
      end
      S_RRESP: if (rready) w_next = S_IDLE;
      S_WWAIT: begin
        if (r_cnt == 4'd0) begin
          w_next      = S_BRESP;
          w_wr_commit = 1'b1;
        end
      end
      S_BRESP: if (bready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_rresp <= OKAY;
      r_bresp <= OKAY;
    end else begin
      r_state <= w_next;
      if (w_cnt_load)
        r_cnt <= LAT_LOAD;
      else if ((r_state == S_RWAIT || r_state == S_WWAIT) && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_rd_commit) begin
        r_rdata <= in_range(w_rd_addr) ? r_mem[word_idx(w_rd_addr)] : '0;
        r_rresp <= in_range(w_rd_addr) ? OKAY : SLVERR;
      end
      if (w_wr_commit)
        r_bresp <= in_range(w_wr_addr) ? OKAY : SLVERR;
    end
  end

  // Request capture; only meaningful while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      if (arvalid) begin
        r_addr <= araddr;
      end else if (w_wr_req) begin
        r_addr  <= awaddr;
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_commit && in_range(w_wr_addr))
      r_mem[word_idx(w_wr_addr)] <= merge_bytes(r_mem[word_idx(w_wr_addr)], w_wr_data, w_wr_strb);
  end

  assign arready = w_arready;
  assign awready = w_awready;
  assign wready  = w_awready;
  assign rvalid  = (r_state == S_RRESP);
  assign bvalid  = (r_state == S_BRESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign bresp   = r_bresp;

endmodule

// File: tb/tb_ysyx_22050854_axi_lite_sram.sv
// Directed bench for the AXI4-Lite SRAM slave: main instance at LATENCY=1,
// a second read-only instance at LATENCY=3 for latency and mid-wait reset checks.
module tb_ysyx_22050854_axi_lite_sram;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic        rst3;
  logic [31:0] araddr3;
  logic        arvalid3;
  logic        arready3;
  logic [63:0] rdata3;
  logic [1:0]  rresp3;
  logic        rvalid3;
  logic        rready3;
  logic        awready3;
  logic        wready3;
  logic [1:0]  bresp3;
  logic        bvalid3;

  int n_chk  = 0;
  int n_pass = 0;

  ysyx_22050854_axi_lite_sram #(.LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  ysyx_22050854_axi_lite_sram #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .araddr(araddr3), .arvalid(arvalid3), .arready(arready3),
    .rdata(rdata3), .rresp(rresp3), .rvalid(rvalid3), .rready(rready3),
    .awaddr(32'h0), .awvalid(1'b0), .awready(awready3),
    .wdata(64'h0), .wstrb(8'h0), .wvalid(1'b0), .wready(wready3),
    .bresp(bresp3), .bvalid(bvalid3), .bready(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp, output int lat);
    logic ok;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    check("aw_handshake", ok, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0; lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (bvalid) begin ok = 1'b1; break; end
    end
    check("b_valid", ok, 1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [63:0] d,
                          output logic [1:0] resp, output int lat);
    logic ok;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    check("ar_handshake", ok, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 1'b0; lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (rvalid) begin ok = 1'b1; break; end
    end
    check("r_valid", ok, 1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] held;
    logic [1:0]  resp;
    int          lat;
    logic        ok;
    logic        seen;

    rst = 1'b1; rst3 = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr3 = '0; arvalid3 = 1'b0; rready3 = 1'b0;
    #2;
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_rresp", rresp, 2'b00);
    check("rst_bresp", bresp, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst3 = 1'b0;
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 0);

    // full-word write then readback, with latency measured in edges from the handshake edge
    axi_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, resp, lat);
    check("wr1_bresp", resp, 2'b00);
    check("wr1_lat", lat, 2);
    axi_read(32'h8000_0010, d, resp, lat);
    check("rd1_data", d, 64'h1122_3344_5566_7788);
    check("rd1_rresp", resp, 2'b00);
    check("rd1_lat", lat, 2);

    // partial strobes
    axi_write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, lat);
    axi_write(32'h8000_0010, 64'h0, 8'h0F, resp, lat);
    axi_read(32'h8000_0010, d, resp, lat);
    check("strb0f_data", d, 64'hFFFF_FFFF_0000_0000);
    axi_read(32'h8000_0015, d, resp, lat);
    check("low_bits_ignored", d, 64'hFFFF_FFFF_0000_0000);
    axi_write(32'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, lat);
    axi_write(32'h8000_0020, 64'h0, 8'hA5, resp, lat);
    axi_read(32'h8000_0020, d, resp, lat);
    check("strba5_data", d, 64'h00FF_00FF_FF00_FF00);

    // read and write requested together: read first, write after the R handshake
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8000_0018; wdata = 64'hCAFE_F00D_1234_5678; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    check("col_arready", arready, 1);
    check("col_awready", {awready, wready}, 2'b00);
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; break; end
      if (awready) break;
    end
    check("col_rvalid", ok, 1);
    check("col_aw_busy", awready, 0);
    check("col_rdata", rdata, 64'hFFFF_FFFF_0000_0000);
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check("col_aw_after", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; break; end
    end
    check("col_bvalid", ok, 1);
    check("col_bresp", bresp, 2'b00);
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(32'h8000_0018, d, resp, lat);
    check("col_wr_data", d, 64'hCAFE_F00D_1234_5678);

    // out-of-range accesses; DEPTH*8 past BASE would alias word 0 if not decoded
    axi_write(32'h8000_0000, 64'hA5A5_0F0F_5A5A_F0F0, 8'hFF, resp, lat);
    check("w0_bresp", resp, 2'b00);
    axi_read(32'h7FFF_FFF8, d, resp, lat);
    check("oor_rresp", resp, 2'b10);
    check("oor_rdata", d, 64'h0);
    axi_write(32'h8000_8000, 64'h0, 8'hFF, resp, lat);
    check("oor_bresp", resp, 2'b10);
    axi_read(32'h8000_0000, d, resp, lat);
    check("oor_untouched", d, 64'hA5A5_0F0F_5A5A_F0F0);
    check("w0_rresp", resp, 2'b00);
    axi_read(32'h8000_7FF8, d, resp, lat);
    check("last_word_rresp", resp, 2'b00);

    // response held while rready is low
    araddr = 32'h8000_0018; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; break; end
    end
    check("hold_rvalid", ok, 1);
    held = rdata;
    check("hold_first_data", held, 64'hCAFE_F00D_1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rvalid_stable", rvalid, 1);
      check("hold_rdata_stable", rdata, held);
      check("hold_arready_low", arready, 0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_rvalid", rvalid, 0);
    check("hold_release_arready", arready, 1);
    rready = 1'b0;

    // LATENCY=3 instance: normal read latency
    araddr3 = 32'h8000_0040; arvalid3 = 1'b1; rready3 = 1'b1;
    @(negedge clk);
    check("l3_arready", arready3, 1);
    @(posedge clk); #1;
    arvalid3 = 1'b0;
    ok = 1'b0; lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (rvalid3) begin ok = 1'b1; break; end
    end
    check("l3_rvalid", ok, 1);
    check("l3_lat", lat, 4);
    check("l3_rresp", rresp3, 2'b00);
    @(posedge clk); #1;
    rready3 = 1'b0;

    // reset while waiting: response dropped, IDLE immediately
    araddr3 = 32'h8000_0040; arvalid3 = 1'b1; rready3 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    arvalid3 = 1'b0;
    @(posedge clk); #1;
    check("l3_in_wait", arready3, 0);
    rst3 = 1'b1;
    #1;
    check("l3_rst_rvalid", rvalid3, 0);
    check("l3_rst_arready", arready3, 1);
    @(posedge clk); #1;
    rst3 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rvalid3) seen = 1'b1;
    end
    check("l3_no_rvalid", seen, 0);
    check("l3_idle_arready", arready3, 1);
    rready3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
